// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with chained carry
//
// Purpose: accepts {A, B, opcode} beats, registers them in S1, computes the
// result and flags on the S1->S2 transfer and presents them from S2.
// An internal carry register feeds ADC/SBB so multi-word arithmetic can be
// chained across consecutive beats.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_flush        synchronous clear of in-flight beats and carry state
//   i_valid        upstream beat valid
//   o_ready        block accepts a beat this cycle
//   A, B           operands (WIDTH bits)
//   opcode         operation select (15 is illegal)
//   o_valid        result beat valid
//   i_ready        downstream accepts result beat
//   result         operation result (WIDTH bits)
//   carry_out      carry / borrow / shifted-out bit
//   zero_flag      value == 0
//   overflow_flag  two's-complement overflow (arithmetic ops only)
//   negative_flag  value MSB
//   o_error        beat carried an illegal opcode
//   o_busy         either stage holds a beat
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             o_error,
  output logic             o_busy
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SAR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_ADC   = 4'd8;
  localparam logic [3:0] OP_SBB   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_ROL   = 4'd11;
  localparam logic [3:0] OP_ROR   = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;

  // S1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;

  // S2: computed result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             cf_q;
  logic             zf_q;
  logic             vf_q;
  logic             nf_q;
  logic             err_q;

  // carry chained into ADC/SBB
  logic             c_q;

  logic             advance;
  logic             accept;

  // S1 moves on when S2 is free now or is being drained this cycle.
  assign advance = s1_valid_q && (!s2_valid_q || i_ready);
  assign o_ready = !i_flush && (!s1_valid_q || advance);
  assign accept  = i_valid && o_ready;

  // Arithmetic at WIDTH+1 bits so bit WIDTH is the carry / unsigned borrow.
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic             add_cin;
  logic             sub_bin;
  logic             add_ov;
  logic             sub_ov;

  always_comb begin
    add_cin = (op_q == OP_ADC) ? c_q : 1'b0;
    sub_bin = (op_q == OP_SBB) ? c_q : 1'b0;
    add_w   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, add_cin};
    sub_w   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, sub_bin};
    add_ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
    sub_ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
  end

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] flag_val;
  logic             cf_d;
  logic             zf_d;
  logic             vf_d;
  logic             nf_d;
  logic             err_d;

  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    vf_d  = 1'b0;
    err_d = 1'b0;
    unique case (op_q)
      OP_ADD, OP_ADC: begin
        res_d = add_w[WIDTH-1:0];
        cf_d  = add_w[WIDTH];
        vf_d  = add_ov;
      end
      OP_SUB, OP_SBB: begin
        res_d = sub_w[WIDTH-1:0];
        cf_d  = sub_w[WIDTH];
        vf_d  = sub_ov;
      end
      OP_CMP: begin
        // result passes A through; flags describe A-B
        res_d = a_q;
        cf_d  = sub_w[WIDTH];
        vf_d  = sub_ov;
      end
      OP_AND:   res_d = a_q & b_q;
      OP_OR:    res_d = a_q | b_q;
      OP_XOR:   res_d = a_q ^ b_q;
      OP_NOT:   res_d = ~a_q;
      OP_PASSB: res_d = b_q;
      OP_SHL: begin
        res_d = {a_q[WIDTH-2:0], 1'b0};
        cf_d  = a_q[WIDTH-1];
      end
      OP_SAR: begin
        res_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        cf_d  = a_q[0];
      end
      OP_SHR: begin
        res_d = {1'b0, a_q[WIDTH-1:1]};
        cf_d  = a_q[0];
      end
      OP_ROL: begin
        res_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        cf_d  = a_q[WIDTH-1];
      end
      OP_ROR: begin
        res_d = {a_q[0], a_q[WIDTH-1:1]};
        cf_d  = a_q[0];
      end
      default: err_d = 1'b1;
    endcase
    flag_val = (op_q == OP_CMP) ? sub_w[WIDTH-1:0] : res_d;
    // an illegal beat reports every flag as 0, including zero
    zf_d = !err_d && (flag_val == '0);
    nf_d = !err_d && flag_val[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      vf_q       <= 1'b0;
      nf_q       <= 1'b0;
      err_q      <= 1'b0;
      c_q        <= 1'b0;
    end else if (i_flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      c_q        <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        a_q        <= A;
        b_q        <= B;
        op_q       <= opcode;
      end else if (advance) begin
        s1_valid_q <= 1'b0;
      end

      if (advance) begin
        s2_valid_q <= 1'b1;
        res_q      <= res_d;
        cf_q       <= cf_d;
        zf_q       <= zf_d;
        vf_q       <= vf_d;
        nf_q       <= nf_d;
        err_q      <= err_d;
        if (!err_d) begin
          c_q <= cf_d;
        end
      end else if (i_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid       = s2_valid_q;
  assign result        = res_q;
  assign carry_out     = cf_q;
  assign zero_flag     = zf_q;
  assign overflow_flag = vf_q;
  assign negative_flag = nf_q;
  assign o_error       = err_q;
  assign o_busy        = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   opcode = '0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero_flag;
  logic         overflow_flag;
  logic         negative_flag;
  logic         o_error;
  logic         o_busy;

  alu_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .A             (A),
    .B             (B),
    .opcode        (opcode),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .result        (result),
    .carry_out     (carry_out),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag),
    .o_error       (o_error),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  // {error, negative, overflow, zero, carry, result}
  wire [12:0] outs = {o_error, negative_flag, overflow_flag, zero_flag, carry_out, result};

  int          n_vec = 0;
  int          n_bad = 0;
  logic [12:0] q[$];
  logic [12:0] seen[$];
  int          mc = 0;
  logic        acc;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] f;    // e n v z c
    logic [7:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference computed with plain integer arithmetic on unsigned/signed values.
  function automatic logic [12:0] ref_alu(input logic [3:0] op, input logic [7:0] a8,
                                          input logic [7:0] b8, input int cin, output int cout);
    int a, b, sa, sb, r, val, c, v, s;
    a = int'(a8);
    b = int'(b8);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; r = 0; s = 0;
    case (op)
      4'd0, 4'd8: begin
        s = (op == 4'd8) ? cin : 0;
        r = a + b + s;
        c = (r > 255) ? 1 : 0;
        v = ((sa + sb + s) > 127 || (sa + sb + s) < -128) ? 1 : 0;
      end
      4'd1, 4'd9, 4'd13: begin
        s = (op == 4'd9) ? cin : 0;
        r = a - b - s;
        c = (r < 0) ? 1 : 0;
        v = ((sa - sb - s) > 127 || (sa - sb - s) < -128) ? 1 : 0;
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  begin r = a * 2;                c = a / 128; end
      4'd6:  begin r = a / 2 + (a & 128);    c = a % 2;   end
      4'd7:  r = 255 - a;
      4'd10: begin r = a / 2;                c = a % 2;   end
      4'd11: begin r = a * 2 + a / 128;      c = a / 128; end
      4'd12: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      4'd14: r = b;
      default: begin
        cout = cin;
        return 13'h1000;
      end
    endcase
    r = r & 255;
    val = r;
    if (op == 4'd13) r = a;
    cout = c;
    return {1'b0, val >= 128, v != 0, val == 0, c != 0, 8'(r)};
  endfunction

  // One clock: drive after the edge, sample at the falling edge, keep the scoreboard.
  task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic rdy, input logic fl);
    logic [12:0] e;
    int co;
    @(posedge clk);
    #1;
    i_valid = v; opcode = op; A = a; B = b; i_ready = rdy; i_flush = fl;
    @(negedge clk);
    acc = 1'b0;
    if (fl) begin
      q.delete();
      mc = 0;
    end else begin
      if (o_valid && i_ready) begin
        seen.push_back(outs);
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL stray_beat: got %0h expected none", outs);
        end else begin
          e = q.pop_front();
          chk("scoreboard", outs, e);
        end
      end
      if (i_valid && o_ready) begin
        acc = 1'b1;
        e = ref_alu(op, a, b, mc, co);
        q.push_back(e);
        mc = co;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 4'd0, 8'h00, 8'h00, rdy, 1'b0);
  endtask

  task automatic flush1();
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() != 0 || o_busy); i++) idle(1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{4'd0,  8'h7F, 8'h01, 5'b01100, 8'h80};
    tbl[1]  = '{4'd0,  8'hFF, 8'h01, 5'b00011, 8'h00};
    tbl[2]  = '{4'd1,  8'h00, 8'h01, 5'b01001, 8'hFF};
    tbl[3]  = '{4'd1,  8'h80, 8'h01, 5'b00100, 8'h7F};
    tbl[4]  = '{4'd2,  8'hF0, 8'h3C, 5'b00000, 8'h30};
    tbl[5]  = '{4'd3,  8'h00, 8'h00, 5'b00010, 8'h00};
    tbl[6]  = '{4'd4,  8'hAA, 8'hFF, 5'b00000, 8'h55};
    tbl[7]  = '{4'd5,  8'h81, 8'h00, 5'b00001, 8'h02};
    tbl[8]  = '{4'd6,  8'h81, 8'h00, 5'b01001, 8'hC0};
    tbl[9]  = '{4'd7,  8'h0F, 8'h00, 5'b01000, 8'hF0};
    tbl[10] = '{4'd8,  8'h01, 8'h02, 5'b00000, 8'h03};
    tbl[11] = '{4'd9,  8'h05, 8'h05, 5'b00010, 8'h00};
    tbl[12] = '{4'd10, 8'h81, 8'h00, 5'b00001, 8'h40};
    tbl[13] = '{4'd11, 8'h81, 8'h00, 5'b00001, 8'h03};
    tbl[14] = '{4'd12, 8'h01, 8'h00, 5'b01001, 8'h80};
    tbl[15] = '{4'd13, 8'h05, 8'h07, 5'b01001, 8'h05};
    tbl[16] = '{4'd13, 8'h80, 8'h01, 5'b00100, 8'h80};
    tbl[17] = '{4'd14, 8'h33, 8'h00, 5'b00010, 8'h00};
    tbl[18] = '{4'd15, 8'h12, 8'h34, 5'b10000, 8'h00};
    tbl[19] = '{4'd13, 8'h42, 8'h42, 5'b00010, 8'h42};

    // reset state
    #1;
    chk("reset_outs", outs, 13'h0);
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    #11;
    rst_n = 1'b1;
    idle(1'b0);
    chk("ready_after_reset", o_ready, 1);

    // single-beat vectors, carry cleared by a flush before each
    for (int i = 0; i < 20; i++) begin
      flush1();
      step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      chk("vec_accept", acc, 1);
      idle(1'b0);
      chk("vec_latency_early", o_valid, 0);
      idle(1'b1);
      chk("vec_valid", o_valid, 1);
      chk($sformatf("vec%0d", i), outs, {tbl[i].f, tbl[i].res});
    end
    drain();

    // ADD FF+01 chained into ADC 00+00
    flush1();
    seen.delete();
    step(1'b1, 4'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    step(1'b1, 4'd8, 8'h00, 8'h00, 1'b1, 1'b0);
    drain();
    chk("chain_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("chain_add", seen[0], 13'h0300);
      chk("chain_adc", seen[1], 13'h0001);
    end

    // five beats against a 4-cycle downstream stall
    begin
      int k = 0;
      logic [12:0] held = '0;
      flush1();
      seen.delete();
      for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
        step(1'b1, 4'(k % 2), 8'(k * 37 + 5), 8'(k * 11 + 3), (cyc >= 4), 1'b0);
        if (cyc == 2) begin
          held = outs;
          chk("stall_ready_low", o_ready, 0);
          chk("stall_valid", o_valid, 1);
        end
        if (cyc == 3) begin
          chk("stall_ready_low2", o_ready, 0);
          chk("stall_stable", outs, held);
        end
        if (acc) k++;
      end
      chk("stall_all_accepted", k, 5);
      drain();
      chk("stall_count", seen.size(), 5);
    end

    // illegal opcode leaves the carry untouched
    flush1();
    seen.delete();
    step(1'b1, 4'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    step(1'b1, 4'd15, 8'h12, 8'h00, 1'b1, 1'b0);
    step(1'b1, 4'd8, 8'h00, 8'h00, 1'b1, 1'b0);
    drain();
    chk("illegal_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("illegal_beat", seen[1], 13'h1000);
      chk("illegal_then_adc", seen[2], 13'h0001);
    end

    // flush with both stages full
    flush1();
    step(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    step(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    step(1'b1, 4'd0, 8'h11, 8'h11, 1'b1, 1'b1);
    chk("flush_full_valid", o_valid, 1);
    chk("flush_no_accept", o_ready, 0);
    idle(1'b1);
    chk("flush_valid_clear", o_valid, 0);
    chk("flush_busy_clear", o_busy, 0);
    seen.delete();
    step(1'b1, 4'd8, 8'h00, 8'h00, 1'b1, 1'b0);
    drain();
    chk("flush_adc_count", seen.size(), 1);
    if (seen.size() == 1) chk("flush_adc", seen[0], 13'h0200);

    // asynchronous reset mid-stream
    step(1'b1, 4'd0, 8'h21, 8'h43, 1'b0, 1'b0);
    step(1'b1, 4'd3, 8'h0F, 8'hF0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_reset_valid", o_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs, 13'h0);
    chk("async_reset_valid", o_valid, 0);
    chk("async_reset_busy", o_busy, 0);
    q.delete();
    mc = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen.delete();
    idle(1'b1);
    chk("post_reset_ready", o_ready, 1);
    repeat (5) idle(1'b1);
    chk("no_stale_beat", seen.size(), 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        flush1();
      end else begin
        step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 8'($urandom),
             8'($urandom), ($urandom_range(0, 9) < 6), 1'b0);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
